// File: rtl/clk_div_pkg.sv
// Shared mode encoding, reset divide ratio and divide-ratio clamp for clk_div_multi.
package clk_div_pkg;

  typedef enum logic {
    MODE_TICK   = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam logic [15:0] DEF_DIV = 16'd50000;

  // A tick needs at least one cycle per period; a square wave needs one high and one low cycle.
  function automatic logic [31:0] clamp_div(input logic [31:0] div, input mode_e mode);
    logic [31:0] lo;
    lo = (mode == MODE_SQUARE) ? 32'd2 : 32'd1;
    return (div < lo) ? lo : div;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active ratio registers, period counter, tick and square outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] DEF_DIV = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] div,
  input  logic             mode,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] sh_div;
  logic [CNT_W-1:0] sh_div_nxt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] cnt;
  mode_e            sh_mode;
  mode_e            sh_mode_nxt;
  mode_e            act_mode;
  logic             wrap;
  logic [CNT_W:0]   half;

  // Shadow value as it will be after this edge, so a same-cycle write reaches the active copy.
  always_comb begin
    sh_div_nxt  = sh_div;
    sh_mode_nxt = sh_mode;
    if (wr) begin
      sh_mode_nxt = mode_e'(mode);
      sh_div_nxt  = CNT_W'(clamp_div(32'(div), mode_e'(mode)));
    end
  end

  // Last count of the period and the high-phase length ceil(D/2).
  always_comb begin
    wrap = (cnt == act_div - 1'b1);
    half = ({1'b0, act_div} + 1'b1) >> 1;
  end

  // Counter, ratio update at period boundary (or at once when idle/synced), registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_div   <= DEF_DIV;
      sh_mode  <= MODE_TICK;
      act_div  <= DEF_DIV;
      act_mode <= MODE_TICK;
      cnt      <= '0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      sh_div  <= sh_div_nxt;
      sh_mode <= sh_mode_nxt;
      if (sync || !en) begin
        cnt      <= '0;
        act_div  <= sh_div_nxt;
        act_mode <= sh_mode_nxt;
        tick     <= 1'b0;
        clk_out  <= 1'b0;
      end else begin
        tick    <= (act_mode == MODE_TICK) && wrap;
        clk_out <= (act_mode == MODE_SQUARE) && ({1'b0, cnt} < half);
        if (wrap) begin
          cnt      <= '0;
          act_div  <= sh_div_nxt;
          act_mode <= sh_mode_nxt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable / square-wave generator: config decode, handshake, channel array.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      N_CH    = 4,
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(clk_div_pkg::DEF_DIV),
  localparam int unsigned     CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_out
);

  logic            in_range;
  logic [N_CH-1:0] wr_vec;

  // Address range check and one-hot write strobe per channel.
  always_comb begin
    in_range = (32'(cfg_ch) < N_CH);
    wr_vec   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg_wr && in_range && (32'(cfg_ch) == i)) wr_vec[i] = 1'b1;
    end
  end

  // Write acknowledge / error pulses, one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr && in_range;
      cfg_err <= cfg_wr && !in_range;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[g]),
      .sync    (sync),
      .wr      (wr_vec[g]),
      .div     (cfg_div),
      .mode    (cfg_mode),
      .tick    (tick[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule
